// File: rtl/mips_multiciclo_pkg.sv
// Shared types and constants for the multicycle MIPS controller:
// state encodings, opcodes, ULAop codes and datapath select values.
package mips_multiciclo_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } estado_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ULAOP_ADD   = 2'b00;
    localparam logic [1:0] ULAOP_SUB   = 2'b01;
    localparam logic [1:0] ULAOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/controle_saidas.sv
// Pure state-to-output decoder for the multicycle controller (Moore outputs).
// Optional macro MULTICICLO_ADDI_EN adds the ADDIEXEC/ADDIWB decodes.
module controle_saidas
    import mips_multiciclo_pkg::*;
(
    input  estado_t    estado_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       Branch_o,
    output logic       IorD_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ULAop_o,
    output logic [1:0] PCSrc_o
);

    always_comb begin
        PCWrite_o  = 1'b0;
        Branch_o   = 1'b0;
        IorD_o     = 1'b0;
        MemWrite_o = 1'b0;
        IRWrite_o  = 1'b0;
        RegDst_o   = 1'b0;
        MemtoReg_o = 1'b0;
        RegWrite_o = 1'b0;
        ALUSrcA_o  = 1'b0;
        ALUSrcB_o  = SRCB_B;
        ULAop_o    = ULAOP_ADD;
        PCSrc_o    = PCSRC_ALU;
        case (estado_i)
            S_FETCH: begin
                // PC+4 and IR load only land on the cycle memory delivers
                ALUSrcB_o = SRCB_FOUR;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            S_DECODE: begin
                ALUSrcB_o = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
            end
            S_MEMREAD: begin
                IorD_o = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg_o = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_MEMWRITE: begin
                IorD_o     = 1'b1;
                MemWrite_o = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA_o = 1'b1;
                ULAop_o   = ULAOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o = 1'b1;
                ULAop_o   = ULAOP_SUB;
                PCSrc_o   = PCSRC_ALUOUT;
                Branch_o  = 1'b1;
            end
            S_JUMP: begin
                PCSrc_o   = PCSRC_JUMP;
                PCWrite_o = 1'b1;
            end
`ifdef MULTICICLO_ADDI_EN
            S_ADDIEXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
            end
            S_ADDIWB: begin
                RegWrite_o = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS controller: state register and next-state logic; outputs
// come from controle_saidas. Optional macro MULTICICLO_ADDI_EN enables addi.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 on mem_ready
// DECODE   | read registers, precompute branch target
// MEMADR   | compute lw/sw effective address
// MEMREAD  | read data memory, wait for mem_ready
// MEMWB    | write MDR to rt
// MEMWRITE | write data memory, wait for mem_ready
// EXECUTE  | R-type ALU operation
// ALUWB    | write ALUOut to rd
// BRANCH   | compare and conditionally load PC
// ADDIEXEC | A + signext imm
// ADDIWB   | write ALUOut to rt
// JUMP     | load jump target into PC
module controle_multiciclo
    import mips_multiciclo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ULAop,
    output logic [1:0] PCSrc,
    output logic [3:0] estado,
    output logic       instr_invalida
);

    estado_t estado_q, estado_d;
    logic    store_q, store_d;
    logic    invalida;
    estado_t estado_dec;
    logic    mem_ready_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= S_FETCH;
            store_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            store_q  <= store_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        store_d  = store_q;
        invalida = 1'b0;
        case (estado_q)
            S_FETCH:    if (mem_ready) estado_d = S_DECODE;
            S_DECODE: begin
                // opcode is only valid now, so remember lw vs sw for MEMADR
                store_d = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: estado_d = S_MEMADR;
                    OP_RTYPE:     estado_d = S_EXECUTE;
                    OP_BEQ:       estado_d = S_BRANCH;
                    OP_J:         estado_d = S_JUMP;
`ifdef MULTICICLO_ADDI_EN
                    OP_ADDI:      estado_d = S_ADDIEXEC;
`endif
                    default: begin
                        estado_d = S_FETCH;
                        invalida = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   estado_d = store_q ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) estado_d = S_MEMWB;
            S_MEMWB:    estado_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) estado_d = S_FETCH;
            S_EXECUTE:  estado_d = S_ALUWB;
            S_ALUWB:    estado_d = S_FETCH;
            S_BRANCH:   estado_d = S_FETCH;
            S_JUMP:     estado_d = S_FETCH;
`ifdef MULTICICLO_ADDI_EN
            S_ADDIEXEC: estado_d = S_ADDIWB;
            S_ADDIWB:   estado_d = S_FETCH;
`endif
            default:    estado_d = S_FETCH;
        endcase
    end

    // During reset the decoder sees a stalled FETCH: FETCH selects, no enables
    assign estado_dec    = reset ? S_FETCH : estado_q;
    assign mem_ready_dec = mem_ready & ~reset;

    controle_saidas u_saidas (
        .estado_i    (estado_dec),
        .mem_ready_i (mem_ready_dec),
        .PCWrite_o   (PCWrite),
        .Branch_o    (Branch),
        .IorD_o      (IorD),
        .MemWrite_o  (MemWrite),
        .IRWrite_o   (IRWrite),
        .RegDst_o    (RegDst),
        .MemtoReg_o  (MemtoReg),
        .RegWrite_o  (RegWrite),
        .ALUSrcA_o   (ALUSrcA),
        .ALUSrcB_o   (ALUSrcB),
        .ULAop_o     (ULAop),
        .PCSrc_o     (PCSrc)
    );

    assign estado         = estado_q;
    assign instr_invalida = invalida & ~reset;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: each driven cycle queues its
// expected state and control word; a negedge monitor pops and compares.
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, instr_invalida;
    logic [1:0] ALUSrcB, ULAop, PCSrc;
    logic [3:0] estado;

    always #5 clk = ~clk;

    controle_multiciclo dut (
        .clk            (clk),
        .reset          (reset),
        .opcode         (opcode),
        .mem_ready      (mem_ready),
        .PCWrite        (PCWrite),
        .Branch         (Branch),
        .IorD           (IorD),
        .MemWrite       (MemWrite),
        .IRWrite        (IRWrite),
        .RegDst         (RegDst),
        .MemtoReg       (MemtoReg),
        .RegWrite       (RegWrite),
        .ALUSrcA        (ALUSrcA),
        .ALUSrcB        (ALUSrcB),
        .ULAop          (ULAop),
        .PCSrc          (PCSrc),
        .estado         (estado),
        .instr_invalida (instr_invalida)
    );

    // Control word: {PCWrite,Branch,IorD,MemWrite,IRWrite,RegDst,MemtoReg,
    //                RegWrite,ALUSrcA,ALUSrcB[1:0],ULAop[1:0],PCSrc[1:0],instr_invalida}
    localparam logic [15:0] W_FETCH_RDY  = 16'h8820;
    localparam logic [15:0] W_FETCH_WAIT = 16'h0020;
    localparam logic [15:0] W_DECODE     = 16'h0060;
    localparam logic [15:0] W_DECODE_INV = 16'h0061;
    localparam logic [15:0] W_MEMADR     = 16'h00C0;
    localparam logic [15:0] W_MEMREAD    = 16'h2000;
    localparam logic [15:0] W_MEMWB      = 16'h0300;
    localparam logic [15:0] W_MEMWRITE   = 16'h3000;
    localparam logic [15:0] W_EXECUTE    = 16'h0090;
    localparam logic [15:0] W_ALUWB      = 16'h0500;
    localparam logic [15:0] W_BRANCH     = 16'h408A;
    localparam logic [15:0] W_JUMP       = 16'h8004;
    localparam logic [15:0] W_ADDIEXEC   = 16'h00C0;
    localparam logic [15:0] W_ADDIWB     = 16'h0100;

    typedef struct packed {
        logic        chk_est;
        logic [3:0]  est;
        logic [15:0] word;
        logic [7:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [15:0] act_word;

    assign act_word = {PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                       RegWrite, ALUSrcA, ALUSrcB, ULAop, PCSrc, instr_invalida};

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (act_word !== e.word) begin
                errors++;
                $display("FAIL ctrl step %0d: got %h expected %h (estado=%0d)",
                         e.tag, act_word, e.word, estado);
            end
            if (e.chk_est) begin
                checks++;
                if (estado !== e.est) begin
                    errors++;
                    $display("FAIL estado step %0d: got %0d expected %0d", e.tag, estado, e.est);
                end
            end
        end
    end

    int step_no = 0;

    task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                        input logic ce, input logic [3:0] est, input logic [15:0] word);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        mem_ready = mr;
        e.chk_est = ce;
        e.est     = est;
        e.word    = word;
        e.tag     = step_no[7:0];
        sb_q.push_back(e);
        step_no++;
    endtask

    task automatic fetch_ok();
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd0, W_FETCH_RDY);
    endtask

    initial begin
        int budget;
        reset     = 1'b1;
        opcode    = 6'b000000;
        mem_ready = 1'b1;

        // reset for two cycles: enables low, FETCH selects
        step(1'b1, 6'b000000, 1'b1, 1'b0, 4'd0, W_FETCH_WAIT);
        step(1'b1, 6'b000000, 1'b1, 1'b1, 4'd0, W_FETCH_WAIT);
        fetch_ok();

        // lw, no waits; opcode cleared after DECODE to show it is latched
        step(1'b0, 6'b100011, 1'b1, 1'b1, 4'd1, W_DECODE);
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd2, W_MEMADR);
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd3, W_MEMREAD);
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd4, W_MEMWB);

        // sw with three wait cycles in MEMWRITE
        fetch_ok();
        step(1'b0, 6'b101011, 1'b1, 1'b1, 4'd1, W_DECODE);
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd2, W_MEMADR);
        for (int i = 0; i < 3; i++)
            step(1'b0, 6'b000000, 1'b0, 1'b1, 4'd5, W_MEMWRITE);
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd5, W_MEMWRITE);

        // fetch with one wait cycle, then R-type
        step(1'b0, 6'b000000, 1'b0, 1'b1, 4'd0, W_FETCH_WAIT);
        fetch_ok();
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd1, W_DECODE);
        step(1'b0, 6'b111111, 1'b1, 1'b1, 4'd6, W_EXECUTE);
        step(1'b0, 6'b111111, 1'b1, 1'b1, 4'd7, W_ALUWB);

        // beq
        fetch_ok();
        step(1'b0, 6'b000100, 1'b1, 1'b1, 4'd1, W_DECODE);
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd8, W_BRANCH);

        // j
        fetch_ok();
        step(1'b0, 6'b000010, 1'b1, 1'b1, 4'd1, W_DECODE);
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd11, W_JUMP);

        // invalid opcode
        fetch_ok();
        step(1'b0, 6'b111111, 1'b1, 1'b1, 4'd1, W_DECODE_INV);

        // addi
        fetch_ok();
`ifdef MULTICICLO_ADDI_EN
        step(1'b0, 6'b001000, 1'b1, 1'b1, 4'd1, W_DECODE);
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd9, W_ADDIEXEC);
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd10, W_ADDIWB);
`else
        step(1'b0, 6'b001000, 1'b1, 1'b1, 4'd1, W_DECODE_INV);
`endif

        // reset during MEMREAD with mem_ready pending: no MEMWB follows
        fetch_ok();
        step(1'b0, 6'b100011, 1'b1, 1'b1, 4'd1, W_DECODE);
        step(1'b0, 6'b000000, 1'b1, 1'b1, 4'd2, W_MEMADR);
        step(1'b1, 6'b000000, 1'b1, 1'b0, 4'd3, W_FETCH_WAIT);
        fetch_ok();
        step(1'b0, 6'b000000, 1'b0, 1'b1, 4'd1, W_DECODE);

        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
